// File: rtl/core_pkg.sv
// Shared types and defaults for the rv32i core pipeline.
package core_pkg;

  typedef enum logic {PASS, HOLD} ifid_mode_e;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam int unsigned DEFAULT_ILEN     = 32;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry instruction hold buffer for IF/ID: freezes the IMEM word across a stall
// and substitutes a NOP for invalid slots.
module inst_hold_buf
  import core_pkg::*;
#(
  parameter int unsigned       ILEN     = DEFAULT_ILEN,
  parameter logic [ILEN-1:0]   NOP_INST = ILEN'(DEFAULT_NOP_INST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ILEN-1:0] i_inst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_valid_q,
  output logic [ILEN-1:0] o_inst
);

  ifid_mode_e      mode_q, mode_d;
  logic [ILEN-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= PASS;
      hold_q <= NOP_INST;
    end else begin
      mode_q <= mode_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    if (i_flush) begin
      mode_d = PASS;
    end else if (i_stall) begin
      // Capture only on the first stall cycle; later cycles see unrelated IMEM data.
      if (mode_q == PASS) begin
        hold_d = i_inst;
        mode_d = HOLD;
      end
    end else begin
      mode_d = PASS;
    end
  end

  always_comb begin
    o_inst = i_inst;
    if (!i_valid_q) begin
      o_inst = NOP_INST;
    end else if (mode_q == HOLD) begin
      o_inst = hold_q;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches fetch PC and valid, passes the synchronous IMEM word
// through, and applies stall/flush control.
module if_id_stage
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter int unsigned     ILEN     = DEFAULT_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(DEFAULT_NOP_INST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_inst,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [ILEN-1:0] o_inst
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (i_flush) begin
      pc_d    = i_pc;
      valid_d = 1'b0;
    end else if (!i_stall) begin
      pc_d    = i_pc;
      valid_d = i_valid;
    end
  end

  inst_hold_buf #(
    .ILEN     (ILEN),
    .NOP_INST (NOP_INST)
  ) u_inst_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .i_inst    (i_inst),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .i_valid_q (valid_q),
    .o_inst    (o_inst)
  );

  // A flush redirects fetch, so it must be allowed to advance even under a stall.
  assign o_ready    = !i_stall | i_flush;
  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_q + XLEN'(4);

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage against a slot-level reference model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_inst;
  logic        i_stall;
  logic        i_flush;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_inst;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the slot in ID and how many stall edges it has sat through.
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_stall_run;
  logic [31:0] m_held;

  if_id_stage #(
    .XLEN     (32),
    .ILEN     (32),
    .RESET_PC (32'h0),
    .NOP_INST (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_pc       (i_pc),
    .i_inst     (i_inst),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_pc       (o_pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_inst     (o_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_valid     = 1'b0;
    m_stall_run = 0;
    m_held      = NOP;
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_inst;
    logic [31:0] exp_p4;
    exp_p4 = m_pc + 32'd4;
    if (!m_valid)             exp_inst = NOP;
    else if (m_stall_run > 0) exp_inst = m_held;
    else                      exp_inst = i_inst;
    check("o_ready", 32'(o_ready), 32'(!i_stall || i_flush));
    check("o_valid", 32'(o_valid), 32'(m_valid));
    check("o_pc", o_pc, m_pc);
    check("o_pc_plus4", o_pc_plus4, exp_p4);
    check("o_inst", o_inst, exp_inst);
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (i_flush) begin
      m_pc        = i_pc;
      m_valid     = 1'b0;
      m_stall_run = 0;
    end else if (i_stall) begin
      if (m_stall_run == 0) m_held = i_inst;
      m_stall_run++;
    end else begin
      m_pc        = i_pc;
      m_valid     = i_valid;
      m_stall_run = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic st, input logic fl);
    @(negedge clk);
    rst     = r;
    i_valid = v;
    i_pc    = pc;
    i_inst  = inst;
    i_stall = st;
    i_flush = fl;
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic        r, v, st, fl;
    logic [31:0] pc, prev_pc, inst;

    rst = 1'b1; i_valid = 1'b1; i_pc = 32'h40; i_inst = 32'h0; i_stall = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check("reset o_pc", o_pc, 32'h0);
    check("reset o_valid", 32'(o_valid), 32'h0);
    check("reset o_inst", o_inst, NOP);
    check("reset o_pc_plus4", o_pc_plus4, 32'h4);

    // Streaming 0x0, 0x4, 0x8 with IMEM words one cycle behind.
    step(0, 1, 32'h0, 32'h0, 0, 0);
    step(0, 1, 32'h4, imem(32'h0), 0, 0);
    step(0, 1, 32'h8, imem(32'h4), 0, 0);
    // Three-cycle stall holding 0x00500093 at pc 0x8.
    step(0, 1, 32'hC, 32'h0050_0093, 1, 0);
    step(0, 1, 32'hC, 32'hDEAD_BEEF, 1, 0);
    check("stall o_inst held", o_inst, 32'h0050_0093);
    step(0, 1, 32'hC, 32'hDEAD_BEEF, 1, 0);
    check("stall o_pc held", o_pc, 32'h8);
    step(0, 1, 32'hC, 32'hDEAD_BEEF, 0, 0);
    check("release o_pc", o_pc, 32'hC);
    step(0, 1, 32'h10, imem(32'hC), 0, 0);
    // Flush with pc_q=0x10, i_pc=0x14.
    step(0, 1, 32'h14, imem(32'h10), 0, 1);
    check("flush o_pc", o_pc, 32'h14);
    check("flush o_inst", o_inst, NOP);
    step(0, 1, 32'h18, imem(32'h14), 0, 0);
    step(0, 1, 32'h1C, imem(32'h18), 0, 0);
    // Stall into HOLD, then stall+flush together.
    step(0, 1, 32'h20, imem(32'h1C), 1, 0);
    step(0, 1, 32'h20, 32'h1234_5678, 1, 0);
    step(0, 1, 32'h24, 32'h1234_5678, 1, 1);
    check("stall+flush o_pc", o_pc, 32'h24);
    check("stall+flush o_valid", 32'(o_valid), 32'h0);
    step(0, 1, 32'h28, imem(32'h24), 0, 0);
    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC, imem(32'h28), 0, 0);
    check("wrap o_pc_plus4", o_pc_plus4, 32'h0);
    step(0, 1, 32'h0, imem(32'hFFFF_FFFC), 0, 0);
    // Reset while in HOLD.
    step(0, 1, 32'h4, imem(32'h0), 1, 0);
    step(0, 1, 32'h4, 32'hCAFE_F00D, 1, 0);
    step(1, 1, 32'h4, 32'hCAFE_F00D, 1, 0);
    check("rst-in-hold o_pc", o_pc, 32'h0);
    check("rst-in-hold o_inst", o_inst, NOP);

    // Random traffic; IMEM data mostly follows the previously captured address.
    prev_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      inst = ($urandom_range(0, 3) == 0) ? $urandom() : imem(prev_pc);
      step(r, v, pc, inst, st, fl);
      prev_pc = m_pc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
